// File: rtl/quad_pkg.sv
// Shared phase/state definitions for the quadrature decoder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package quad_pkg;

    // Low two bits of each phase state are the {A,B} levels it represents,
    // so a phase can be mapped to a state with a plain cast.
    typedef enum logic [2:0] {
        ST_P00  = 3'b000,
        ST_P01  = 3'b001,
        ST_P10  = 3'b010,
        ST_P11  = 3'b011,
        ST_INIT = 3'b100
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Forward rotation (A leads B): 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] fwd_next(input logic [1:0] ph);
        case (ph)
            PH_00:   fwd_next = PH_10;
            PH_10:   fwd_next = PH_11;
            PH_11:   fwd_next = PH_01;
            default: fwd_next = PH_00;
        endcase
    endfunction

    // Reverse rotation: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] rev_next(input logic [1:0] ph);
        case (ph)
            PH_00:   rev_next = PH_01;
            PH_01:   rev_next = PH_11;
            PH_11:   rev_next = PH_10;
            default: rev_next = PH_00;
        endcase
    endfunction

    function automatic state_t phase_state(input logic [1:0] ph);
        phase_state = state_t'({1'b0, ph});
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Two-flop synchronizer for the {A,B} pair, optional 2-sample glitch filter.
// Latency: 2 cycles to o_ab (3 with QUAD_GLITCH_FILTER_EN defined).
// Backpressure: none; o_vld rises once real samples have flushed the pipeline.
// Ports: i_clk, i_rst (sync active-high), i_a/i_b async inputs,
//        o_ab synchronized {A,B}, o_vld high once o_ab carries post-reset data.
// Build option: QUAD_GLITCH_FILTER_EN accepts a new {A,B} only after two
// consecutive identical synchronized samples.
module quad_sync (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a,
    input  logic       i_b,
    output logic [1:0] o_ab,
    output logic       o_vld
);
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] r_vld;   // tracks how far real data has travelled down the chain

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1  <= 2'b00;
            r_s2  <= 2'b00;
            r_vld <= 2'b00;
        end else begin
            r_s1  <= {i_a, i_b};
            r_s2  <= r_s1;
            r_vld <= {r_vld[0], 1'b1};
        end
    end

`ifdef QUAD_GLITCH_FILTER_EN
    logic [1:0] r_prev;
    logic [1:0] r_hold;
    logic       r_vld3;
    logic       r_have;
    logic       w_eq;
    logic       w_acc;

    // The accepted value is presented combinationally on the second matching
    // sample, so the filter costs exactly one extra cycle.
    assign w_eq  = r_vld3 && (r_s2 == r_prev);
    assign w_acc = w_eq || r_have;
    assign o_ab  = w_eq ? r_s2 : r_hold;
    assign o_vld = w_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 2'b00;
            r_hold <= 2'b00;
            r_vld3 <= 1'b0;
            r_have <= 1'b0;
        end else begin
            r_prev <= r_s2;
            r_hold <= o_ab;
            r_vld3 <= r_vld[1];
            r_have <= w_acc;
        end
    end
`else
    assign o_ab  = r_s2;
    assign o_vld = r_vld[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: signed position, angle within revolution, step/rev pulses.
// Latency: 3 cycles from capturing edge to pos/step (4 with QUAD_GLITCH_FILTER_EN).
// Backpressure: none; every valid edge is counted, pulses are single-cycle.
// Ports: clk, rst (sync active-high), sensorA/sensorB async quadrature inputs,
//        clr sync clear; pos, angle, dir, step, rev, err (sticky) outputs.
// Build option: QUAD_GLITCH_FILTER_EN enables the input glitch filter in quad_sync.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CPR   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sensorA,
    input  logic                      sensorB,
    input  logic                      clr,
    output logic signed [WIDTH-1:0]   pos,
    output logic [$clog2(CPR)-1:0]    angle,
    output logic                      dir,
    output logic                      step,
    output logic                      rev,
    output logic                      err
);
    localparam int AW = $clog2(CPR);
    localparam logic [AW-1:0] ANG_MAX = AW'(CPR - 1);

    logic [1:0] w_ab;
    logic       w_vld;

    quad_sync u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_a   (sensorA),
        .i_b   (sensorB),
        .o_ab  (w_ab),
        .o_vld (w_vld)
    );

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_fwd;
    logic                     w_rev;
    logic                     w_bad;
    logic [1:0]               w_cur_ph;
    logic signed [WIDTH-1:0]  r_pos;
    logic [AW-1:0]            r_angle;
    logic                     r_dir;
    logic                     r_step;
    logic                     r_rev;
    logic                     r_err;

    assign w_cur_ph = r_state[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_rev       = 1'b0;
        w_bad       = 1'b0;
        if (w_vld) begin
            if (r_state == ST_INIT) begin
                // first real sample only establishes the phase
                w_state_nxt = phase_state(w_ab);
            end else if (w_ab == w_cur_ph) begin
                w_state_nxt = r_state;
            end else if (w_ab == fwd_next(w_cur_ph)) begin
                w_fwd       = 1'b1;
                w_state_nxt = phase_state(w_ab);
            end else if (w_ab == rev_next(w_cur_ph)) begin
                w_rev       = 1'b1;
                w_state_nxt = phase_state(w_ab);
            end else begin
                // both channels moved at once: direction unknown, resync
                w_bad       = 1'b1;
                w_state_nxt = phase_state(w_ab);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_pos   <= '0;
            r_angle <= '0;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_rev   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // phase is always absorbed, even when clr discards the count
            r_state <= w_state_nxt;
            r_step  <= 1'b0;
            r_rev   <= 1'b0;
            if (clr) begin
                r_pos   <= '0;
                r_angle <= '0;
                r_err   <= 1'b0;
            end else if (w_fwd) begin
                r_pos  <= r_pos + WIDTH'(1);
                r_dir  <= 1'b1;
                r_step <= 1'b1;
                if (r_angle == ANG_MAX) begin
                    r_angle <= '0;
                    r_rev   <= 1'b1;
                end else begin
                    r_angle <= r_angle + AW'(1);
                end
            end else if (w_rev) begin
                r_pos  <= r_pos - WIDTH'(1);
                r_dir  <= 1'b0;
                r_step <= 1'b1;
                if (r_angle == '0) begin
                    r_angle <= ANG_MAX;
                    r_rev   <= 1'b1;
                end else begin
                    r_angle <= r_angle - AW'(1);
                end
            end else if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pos   = r_pos;
    assign angle = r_angle;
    assign dir   = r_dir;
    assign step  = r_step;
    assign rev   = r_rev;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (WIDTH=32, CPR=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_quad_decoder;
    localparam int WIDTH = 32;
    localparam int CPR   = 8;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sensorA;
    logic                    sensorB;
    logic                    clr;
    logic signed [WIDTH-1:0] pos;
    logic [2:0]              angle;
    logic                    dir;
    logic                    step;
    logic                    rev;
    logic                    err;

    quad_decoder #(.WIDTH(WIDTH), .CPR(CPR)) dut (
        .clk     (clk),
        .rst     (rst),
        .sensorA (sensorA),
        .sensorB (sensorB),
        .clr     (clr),
        .pos     (pos),
        .angle   (angle),
        .dir     (dir),
        .step    (step),
        .rev     (rev),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;
    int n_rev   = 0;

    // Reference model: phase index along the forward Gray cycle, plain integers.
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int   m_ph, m_pos, m_ang, m_steps, m_revs;
    logic m_dir, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (step === 1'b1) n_step++;
        if (rev === 1'b1) n_rev++;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pos"},   pos,            32'(m_pos));
        chk({tag, ".angle"}, 32'(angle),     32'(m_ang));
        chk({tag, ".dir"},   32'(dir),       32'(m_dir));
        chk({tag, ".err"},   32'(err),       32'(m_err));
        chk({tag, ".nstep"}, 32'(n_step),    32'(m_steps));
        chk({tag, ".nrev"},  32'(n_rev),     32'(m_revs));
    endtask

    // Move inputs to phase idx, optionally with clr landing on the cycle the
    // edge registers; checks the exact latency and single-cycle pulse width.
    task automatic drive(input string tag, input int idx, input bit with_clr, input int hold);
        int d;
        bit mv;
        bit wrap;
        d    = (idx - m_ph + 4) % 4;
        mv   = (d == 1 || d == 3) && !with_clr;
        wrap = 1'b0;
        if (with_clr) begin
            m_pos = 0; m_ang = 0; m_err = 1'b0;
        end else if (d == 1) begin
            m_pos++; wrap = (m_ang == CPR - 1); m_ang = (m_ang + 1) % CPR; m_dir = 1'b1;
        end else if (d == 3) begin
            m_pos--; wrap = (m_ang == 0); m_ang = (m_ang + CPR - 1) % CPR; m_dir = 1'b0;
        end else if (d == 2) begin
            m_err = 1'b1;
        end
        m_ph = idx;
        if (mv) m_steps++;
        if (wrap) m_revs++;
        @(negedge clk);
        {sensorA, sensorB} = gray[idx];
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (k == LAT - 1) begin
                chk({tag, ".early_step"}, 32'(step), 32'd0);
                if (with_clr) begin
                    @(negedge clk);
                    clr = 1'b1;
                end
            end
            if (k == LAT) begin
                clr = 1'b0;
                chk({tag, ".step"}, 32'(step), 32'(mv));
                chk({tag, ".rev"},  32'(rev),  32'(wrap));
                check_state(tag);
            end
            if (k == LAT + 1) chk({tag, ".step_width"}, 32'(step), 32'd0);
        end
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_pos = 0; m_ang = 0; m_err = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag, input int idx);
        @(negedge clk);
        {sensorA, sensorB} = gray[idx];
        rst = 1'b1;
        clr = 1'b1;
        tick();
        tick();
        chk({tag, ".rst_pos"},   pos,         32'd0);
        chk({tag, ".rst_angle"}, 32'(angle),  32'd0);
        chk({tag, ".rst_dir"},   32'(dir),    32'd0);
        chk({tag, ".rst_step"},  32'(step),   32'd0);
        chk({tag, ".rst_rev"},   32'(rev),    32'd0);
        chk({tag, ".rst_err"},   32'(err),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        n_step = 0; n_rev = 0;
        m_ph = idx; m_pos = 0; m_ang = 0; m_dir = 1'b0; m_err = 1'b0;
        m_steps = 0; m_revs = 0;
        repeat (8) tick();
        check_state({tag, ".post"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int idx;
        rst = 1'b1; clr = 1'b0; sensorA = 1'b0; sensorB = 1'b0;
        m_ph = 0; m_pos = 0; m_ang = 0; m_dir = 1'b0; m_err = 1'b0;
        m_steps = 0; m_revs = 0;

        do_reset("reset", 0);

        // two full forward revolutions of the Gray cycle
        for (int r = 0; r < 2; r++)
            for (int i = 1; i <= 4; i++)
                drive("fwd", i % 4, 1'b0, 10);
        chk("fwd2.pos",   pos,          32'd8);
        chk("fwd2.angle", 32'(angle),   32'd0);
        chk("fwd2.dir",   32'(dir),     32'd1);
        chk("fwd2.steps", 32'(n_step),  32'd8);
        chk("fwd2.revs",  32'(n_rev),   32'd1);

        do_clear("clr1");
        chk("clr1.dir_kept", 32'(dir), 32'd1);

        // one reverse edge from zero: underflow to all ones, angle wraps to 7
        drive("rev1", 3, 1'b0, 8);
        chk("rev1.pos_ones", pos,        32'hFFFF_FFFF);
        chk("rev1.angle7",   32'(angle), 32'd7);

        // two-bit jump 01 -> 10, then a legal edge, then clear
        drive("jump", 1, 1'b0, 8);
        drive("jump_hold", 1, 1'b0, 6);
        drive("after_jump", 2, 1'b0, 8);
        do_clear("clr2");

        // clr coinciding with a registering edge; following edge counts from 0
        drive("clr_step", 3, 1'b1, 8);
        drive("post_clr", 0, 1'b0, 8);
        chk("post_clr.pos1", pos, 32'd1);

        // single-cycle pulse on sensorA from phase 00
        a0 = m_ang;
        @(negedge clk);
        sensorA = 1'b1;
        tick();
        @(negedge clk);
        sensorA = 1'b0;
        repeat (8) tick();
`ifndef QUAD_GLITCH_FILTER_EN
        m_steps += 2;
        m_dir = 1'b0;
        if (a0 == CPR - 1) m_revs += 2;
`endif
        check_state("glitch");

        // randomized moves, legal and illegal, against the model
        for (int i = 0; i < 40; i++) begin
            idx = int'($urandom_range(0, 3));
            drive("rand", idx, 1'b0, 7);
        end

        // reset mid-rotation with inputs at 11, then a forward edge from 11
        drive("pre_rst", (m_ph + 1) % 4, 1'b0, 6);
        do_reset("rst11", 2);
        drive("from11", 3, 1'b0, 8);
        chk("from11.pos", pos, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
